button_conditioner: RTL and testbench
=====================================

# button_conditioner

Input-conditioning stage directly upstream of the game-world logic. Takes the three raw active-high pushbuttons (jump, left, right) and produces synchronized, debounced levels, a single-shot jump request held under a request/acknowledge handshake, and a resolved 2-bit movement direction. Runs on the 100 MHz system clock; the world logic consumes its outputs in place of the raw buttons.

## Interface

- DEBOUNCE_CYCLES, default 1000000: consecutive stable samples needed to accept a level change (10 ms at 100 MHz); legal range 2 to 2^CNT_W-1.
- CNT_W, default 20: debounce counter width.

- clk  in  1  system clock, 100 MHz; one clock, all logic on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- jump_in  in  1  raw jump button, asynchronous to clk.
- left_in  in  1  raw left button, asynchronous.
- right_in  in  1  raw right button, asynchronous.
- jump_ack  in  1  one-cycle pulse from world logic: pending jump consumed.
- jump_lvl  out  1  debounced jump level.
- left_lvl  out  1  debounced left level.
- right_lvl  out  1  debounced right level.
- jump_press  out  1  one-cycle pulse on each accepted jump press.
- jump_req  out  1  jump request, held until acknowledged.
- move_dir  out  2  00 idle, 01 right, 10 left; 11 never driven.

## Operation

- Synchronizer: two flip-flops per raw input, reset to 0.
- Debounce, per channel: stable state s (the *_lvl output), counter c. If synced input equals s: c <= 0. Otherwise c increments; when c == DEBOUNCE_CYCLES-1 and input still differs, s <= input, c <= 0. A single agreeing sample clears c (glitches shorter than DEBOUNCE_CYCLES never pass). No counter wrap: c never exceeds DEBOUNCE_CYCLES-1.
- jump_press: high exactly one cycle, the cycle after jump_lvl goes 0->1.
- Jump FSM, states IDLE, PEND, HELD:
  - IDLE: jump_req=0; jump_lvl rising edge -> PEND. jump_ack ignored.
  - PEND: jump_req=1; jump_ack -> HELD if jump_lvl=1, else IDLE. Release before ack keeps PEND (press still delivered). New presses while PEND are absorbed (no second request).
  - HELD: jump_req=0; jump_lvl=0 -> IDLE. Holding the button never re-requests (no auto-repeat).
- Direction arbiter: register last ∈ {L,R}, reset R. left_lvl rise sets L, right_lvl rise sets R; both rising same cycle sets R. move_dir: neither held 00; only left 10; only right 01; both held -> last (L=10, R=01).

## Timing

- Reset (async assert, any state): sync flops, *_lvl, c, jump_press, jump_req, move_dir all 0; FSM IDLE; last=R. Outputs valid from first clock after rst deasserts.
- Raw edge to *_lvl change: 2 sync cycles + DEBOUNCE_CYCLES cycles, ±1 for asynchronous input sampling.
- *_lvl change at edge T -> jump_press, jump_req, move_dir update at T+1 (all registered, no combinational input-to-output paths).
- jump_ack at edge T while PEND -> jump_req=0 at T+1.
- Simultaneous jump_lvl rise and jump_ack in IDLE: go PEND; ack is discarded.
- Reset mid-PEND: pending request is dropped, not replayed.

## Test plan

All with DEBOUNCE_CYCLES=4.
- Reset: hold rst mid-debounce with all inputs 1 -> all outputs 0 asynchronously; after release, inputs still 1 -> *_lvl=1 after 2+4 cycles, move_dir=01 (both held, last=R).
- Glitch rejection: jump_in high 3 cycles then low -> jump_lvl, jump_press, jump_req stay 0; high 6 cycles -> jump_lvl=1 and exactly one jump_press pulse.
- Handshake: press and hold jump -> jump_req=1 until jump_ack pulse, 0 next cycle, stays 0 while held (FSM HELD); release, press again -> new jump_req.
- Release before ack: press, release fully, then jump_ack 20 cycles later -> jump_req high throughout until ack, FSM returns to IDLE.
- Direction: left held -> 10; add right -> 01; release right -> 10; release left -> 00; both rising same cycle -> 01.
- Double press while PEND: two clean presses, no ack -> one jump_req, two jump_press pulses; single ack clears it.

Source files
------------

// File: rtl/button_conditioner.sv
// Conditions the raw jump/left/right pushbuttons: synchronize, debounce, single-shot
// jump request under a req/ack handshake, and a resolved movement direction.
module button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned CNT_W           = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       jump_in,
  input  logic       left_in,
  input  logic       right_in,
  input  logic       jump_ack,
  output logic       jump_lvl,
  output logic       left_lvl,
  output logic       right_lvl,
  output logic       jump_press,
  output logic       jump_req,
  output logic [1:0] move_dir
);

  localparam int unsigned NCH = 3;
  localparam int unsigned CH_JUMP  = 0;
  localparam int unsigned CH_LEFT  = 1;
  localparam int unsigned CH_RIGHT = 2;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] DIR_IDLE  = 2'b00;
  localparam logic [1:0] DIR_RIGHT = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    PEND = 2'b01,
    HELD = 2'b10
  } jump_state_t;

  logic [NCH-1:0]   raw;
  logic [NCH-1:0]   sync1;
  logic [NCH-1:0]   sync2;
  logic [NCH-1:0]   lvl;
  logic [NCH-1:0]   lvl_q;
  logic [NCH-1:0]   rise;
  logic [CNT_W-1:0] cnt [NCH];

  jump_state_t state;
  logic        last_left;
  logic        next_last_left;

  assign raw  = {right_in, left_in, jump_in};
  assign rise = lvl & ~lvl_q;

  assign jump_lvl  = lvl[CH_JUMP];
  assign left_lvl  = lvl[CH_LEFT];
  assign right_lvl = lvl[CH_RIGHT];

  // Two-flop synchronizer and per-channel debounce; any agreeing sample restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      lvl   <= '0;
      lvl_q <= '0;
      for (int i = 0; i < NCH; i++) cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      lvl_q <= lvl;
      for (int i = 0; i < NCH; i++) begin
        if (sync2[i] == lvl[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          lvl[i] <= sync2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Jump handshake: one request per press, no auto-repeat while held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      jump_req   <= 1'b0;
      jump_press <= 1'b0;
    end else begin
      jump_press <= rise[CH_JUMP];
      case (state)
        IDLE: begin
          if (rise[CH_JUMP]) begin
            state    <= PEND;
            jump_req <= 1'b1;
          end
        end
        PEND: begin
          if (jump_ack) begin
            state    <= lvl[CH_JUMP] ? HELD : IDLE;
            jump_req <= 1'b0;
          end
        end
        HELD: begin
          if (!lvl[CH_JUMP]) state <= IDLE;
        end
        default: begin
          state    <= IDLE;
          jump_req <= 1'b0;
        end
      endcase
    end
  end

  // Most recent direction press wins when both are held; a tie goes right.
  always_comb begin
    next_last_left = last_left;
    if (rise[CH_RIGHT])     next_last_left = 1'b0;
    else if (rise[CH_LEFT]) next_last_left = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_left <= 1'b0;
      move_dir  <= DIR_IDLE;
    end else begin
      last_left <= next_last_left;
      case ({lvl[CH_LEFT], lvl[CH_RIGHT]})
        2'b10:   move_dir <= DIR_LEFT;
        2'b01:   move_dir <= DIR_RIGHT;
        2'b11:   move_dir <= next_last_left ? DIR_LEFT : DIR_RIGHT;
        default: move_dir <= DIR_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner with a short debounce window: vector table plus reset sequence.
module tb_button_conditioner;

  localparam int unsigned DEB   = 4;
  localparam int unsigned CNT_W = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       jump_in = 1'b0, left_in = 1'b0, right_in = 1'b0, jump_ack = 1'b0;
  logic       jump_lvl, left_lvl, right_lvl, jump_press, jump_req;
  logic [1:0] move_dir;

  button_conditioner #(.DEBOUNCE_CYCLES(DEB), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .jump_in(jump_in), .left_in(left_in), .right_in(right_in), .jump_ack(jump_ack),
    .jump_lvl(jump_lvl), .left_lvl(left_lvl), .right_lvl(right_lvl),
    .jump_press(jump_press), .jump_req(jump_req), .move_dir(move_dir)
  );

  always #5 clk = ~clk;

  // {jump_lvl, left_lvl, right_lvl, jump_press, jump_req, move_dir}
  typedef logic [6:0] out_t;

  typedef struct {
    string name;
    logic  j, l, r, a;
    int    cycles;
    out_t  exp;
  } vec_t;

  vec_t tbl[$];
  out_t exp_q[$];
  int   n_pass = 0;
  int   n_checks = 0;

  function automatic out_t sample();
    return {jump_lvl, left_lvl, right_lvl, jump_press, jump_req, move_dir};
  endfunction

  task automatic check(input string name, input out_t got, input out_t exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got jl/ll/rl/press/req/dir=%b_%b_%b_%b_%b_%b expected %b_%b_%b_%b_%b_%b",
                  name, got[6], got[5], got[4], got[3], got[2], got[1:0],
                  exp[6], exp[5], exp[4], exp[3], exp[2], exp[1:0]);
  endtask

  task automatic add(input string n, input logic j, input logic l, input logic r, input logic a,
                     input int cyc, input logic jl, input logic ll, input logic rl,
                     input logic p, input logic q, input logic [1:0] d);
    vec_t v;
    v.name = n; v.j = j; v.l = l; v.r = r; v.a = a; v.cycles = cyc;
    v.exp = {jl, ll, rl, p, q, d};
    tbl.push_back(v);
  endtask

  initial begin
    // name           j  l  r  a cyc  jl ll rl p  q  dir
    add("glitch_hi",    1, 0, 0, 0, 3,  0, 0, 0, 0, 0, 2'b00);
    add("glitch_rej",   0, 0, 0, 0, 3,  0, 0, 0, 0, 0, 2'b00);
    add("glitch_idle",  0, 0, 0, 0, 5,  0, 0, 0, 0, 0, 2'b00);
    add("press_lvl",    1, 0, 0, 0, 6,  1, 0, 0, 0, 0, 2'b00);
    add("press_pulse",  1, 0, 0, 0, 1,  1, 0, 0, 1, 1, 2'b00);
    add("press_once",   1, 0, 0, 0, 1,  1, 0, 0, 0, 1, 2'b00);
    add("req_held",     1, 0, 0, 0, 5,  1, 0, 0, 0, 1, 2'b00);
    add("ack_clears",   1, 0, 0, 1, 1,  1, 0, 0, 0, 0, 2'b00);
    add("held_norep",   1, 0, 0, 0, 5,  1, 0, 0, 0, 0, 2'b00);
    add("release",      0, 0, 0, 0, 6,  0, 0, 0, 0, 0, 2'b00);
    add("rel_idle",     0, 0, 0, 0, 2,  0, 0, 0, 0, 0, 2'b00);
    add("repress",      1, 0, 0, 0, 7,  1, 0, 0, 1, 1, 2'b00);
    add("repress_ack",  1, 0, 0, 1, 1,  1, 0, 0, 0, 0, 2'b00);
    add("repress_rel",  0, 0, 0, 0, 8,  0, 0, 0, 0, 0, 2'b00);
    add("rba_press",    1, 0, 0, 0, 7,  1, 0, 0, 1, 1, 2'b00);
    add("rba_release",  0, 0, 0, 0, 8,  0, 0, 0, 0, 1, 2'b00);
    add("rba_wait",     0, 0, 0, 0, 20, 0, 0, 0, 0, 1, 2'b00);
    add("rba_ack",      0, 0, 0, 1, 1,  0, 0, 0, 0, 0, 2'b00);
    add("rba_after",    0, 0, 0, 0, 3,  0, 0, 0, 0, 0, 2'b00);
    add("rba_newpress", 1, 0, 0, 0, 7,  1, 0, 0, 1, 1, 2'b00);
    add("rba_newack",   1, 0, 0, 1, 1,  1, 0, 0, 0, 0, 2'b00);
    add("rba_newrel",   0, 0, 0, 0, 8,  0, 0, 0, 0, 0, 2'b00);
    add("dbl_first",    1, 0, 0, 0, 7,  1, 0, 0, 1, 1, 2'b00);
    add("dbl_rel",      0, 0, 0, 0, 8,  0, 0, 0, 0, 1, 2'b00);
    add("dbl_lvl",      1, 0, 0, 0, 6,  1, 0, 0, 0, 1, 2'b00);
    add("dbl_pulse2",   1, 0, 0, 0, 1,  1, 0, 0, 1, 1, 2'b00);
    add("dbl_onereq",   1, 0, 0, 0, 1,  1, 0, 0, 0, 1, 2'b00);
    add("dbl_ack",      1, 0, 0, 1, 1,  1, 0, 0, 0, 0, 2'b00);
    add("dbl_done",     0, 0, 0, 0, 8,  0, 0, 0, 0, 0, 2'b00);
    add("dir_left",     0, 1, 0, 0, 7,  0, 1, 0, 0, 0, 2'b10);
    add("dir_add_r",    0, 1, 1, 0, 7,  0, 1, 1, 0, 0, 2'b01);
    add("dir_rel_r",    0, 1, 0, 0, 7,  0, 1, 0, 0, 0, 2'b10);
    add("dir_rel_l",    0, 0, 0, 0, 7,  0, 0, 0, 0, 0, 2'b00);
    add("dir_both_tie", 0, 1, 1, 0, 7,  0, 1, 1, 0, 0, 2'b01);
    add("dir_only_l",   0, 1, 0, 0, 7,  0, 1, 0, 0, 0, 2'b10);
    add("dir_r_later",  0, 1, 1, 0, 7,  0, 1, 1, 0, 0, 2'b01);
    add("dir_only_r",   0, 0, 1, 0, 7,  0, 0, 1, 0, 0, 2'b01);
    add("dir_l_later",  0, 1, 1, 0, 7,  0, 1, 1, 0, 0, 2'b10);
    add("dir_none",     0, 0, 0, 0, 8,  0, 0, 0, 0, 0, 2'b00);

    // Reset state, then all buttons held from release.
    repeat (3) @(negedge clk);
    check("reset_state", sample(), 7'b0);
    rst = 1'b0;
    jump_in = 1'b1; left_in = 1'b1; right_in = 1'b1;
    repeat (10) @(negedge clk);
    check("all_held", sample(), {1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'b01});

    // Asynchronous reset mid-cycle, held while inputs stay high.
    #2 rst = 1'b1;
    #1 check("async_reset", sample(), 7'b0);
    @(negedge clk);
    @(negedge clk);
    check("reset_held", sample(), 7'b0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("post_rst_deb", sample(), 7'b0);
    @(negedge clk);
    check("post_rst_lvl", sample(), {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00});
    @(negedge clk);
    check("post_rst_out", sample(), {1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'b01});

    // Reset mid-PEND drops the request; start the table from a clean state.
    jump_in = 1'b0; left_in = 1'b0; right_in = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("pend_dropped", sample(), 7'b0);

    foreach (tbl[i]) begin
      jump_in = tbl[i].j; left_in = tbl[i].l; right_in = tbl[i].r; jump_ack = tbl[i].a;
      exp_q.push_back(tbl[i].exp);
      repeat (tbl[i].cycles) @(negedge clk);
      check(tbl[i].name, sample(), exp_q.pop_front());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
